// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl
// ---------------------------------------------------------------------------
// Arbitrates one single-port data memory between a CPU core, a host access
// port and a built-in clear engine that zeroes every location.
//
// States:
//   CLEAR - sweeps every address from 0 up to all-ones, writing 0x00.
//   RUN   - the core owns the memory combinationally.
//   HOST  - one cycle in which the host performs a single read or write.
//
// Configuration macro:
//   DMC_AUTO_CLEAR_EN - defined: reset enters CLEAR, so memory is zeroed
//                       after every reset.
//                       undefined: reset enters RUN, and memory is cleared
//                       only on clear_req.
//
// Ports:
//   clock, reset        sole clock, synchronous active-high reset
//   core_cursor         core address
//   core_write_val      core write data
//   core_write_enable   core write strobe
//   core_read_val       read data to the core (0x00 while stalled)
//   core_stall          core must hold its state while high
//   clear_req           request a full-memory clear
//   clear_busy          high while the clear sweep runs
//   host_req, host_we   host access request and write select
//   host_addr           host address
//   host_wdata          host write data
//   host_ack            one-cycle pulse after the HOST cycle
//   host_rdata          registered host read data
//   mem_cursor          memory address
//   mem_write_val       memory write data
//   mem_write_enable    memory write strobe
//   mem_read_val        asynchronous memory read data
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DATA_ADDR_SIZE = 16
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [DATA_ADDR_SIZE-1:0] core_cursor,
    input  logic [7:0]                core_write_val,
    input  logic                      core_write_enable,
    output logic [7:0]                core_read_val,
    output logic                      core_stall,
    input  logic                      clear_req,
    output logic                      clear_busy,
    input  logic                      host_req,
    input  logic                      host_we,
    input  logic [DATA_ADDR_SIZE-1:0] host_addr,
    input  logic [7:0]                host_wdata,
    output logic                      host_ack,
    output logic [7:0]                host_rdata,
    output logic [DATA_ADDR_SIZE-1:0] mem_cursor,
    output logic [7:0]                mem_write_val,
    output logic                      mem_write_enable,
    input  logic [7:0]                mem_read_val
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_RUN   = 2'd1,
        S_HOST  = 2'd2
    } state_t;

    localparam logic [DATA_ADDR_SIZE-1:0] CNT_LAST = '1;

`ifdef DMC_AUTO_CLEAR_EN
    localparam state_t RESET_STATE = S_CLEAR;
`else
    localparam state_t RESET_STATE = S_RUN;
`endif

    state_t                    state;
    logic [DATA_ADDR_SIZE-1:0] clear_cnt;

    // Controller state, clear counter and host response registers.
    // A clear request wins over a host request in the same RUN cycle.
    // A request that is still high in the ack cycle is not served a second
    // time, so a held host_req produces one access per pulse of host_ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= RESET_STATE;
            clear_cnt  <= '0;
            host_ack   <= 1'b0;
            host_rdata <= 8'h00;
        end else begin
            host_ack <= 1'b0;
            case (state)
                S_CLEAR: begin
                    // clear_req is ignored here; the sweep always completes
                    clear_cnt <= clear_cnt + DATA_ADDR_SIZE'(1);
                    if (clear_cnt == CNT_LAST) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (clear_req) begin
                        state     <= S_CLEAR;
                        clear_cnt <= '0;
                    end else if (host_req && !host_ack) begin
                        state <= S_HOST;
                    end
                end
                S_HOST: begin
                    host_rdata <= mem_read_val;
                    host_ack   <= 1'b1;
                    state      <= S_RUN;
                end
                default: begin
                    state <= S_RUN;
                end
            endcase
        end
    end

    // Memory port steering. Exactly one agent owns the port in each state,
    // so the core and the host can never write in the same cycle. The stall
    // and busy flags depend on the registered state only.
    always_comb begin
        mem_cursor       = core_cursor;
        mem_write_val    = core_write_val;
        mem_write_enable = core_write_enable;
        core_read_val    = mem_read_val;
        core_stall       = 1'b0;
        clear_busy       = 1'b0;
        case (state)
            S_CLEAR: begin
                mem_cursor       = clear_cnt;
                mem_write_val    = 8'h00;
                mem_write_enable = 1'b1;
                core_read_val    = 8'h00;
                core_stall       = 1'b1;
                clear_busy       = 1'b1;
            end
            S_HOST: begin
                mem_cursor       = host_addr;
                mem_write_val    = host_wdata;
                mem_write_enable = host_we;
                core_read_val    = 8'h00;
                core_stall       = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 Parameter: DATA_ADDR_SIZE, default 16, width of every data-memory address in bits.
REQ-002 clock  input  1  sole clock; all state updates on posedge clock.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clock.
REQ-004 core_cursor  input  DATA_ADDR_SIZE  core data address.
REQ-005 core_write_val  input  8  core write data.
REQ-006 core_write_enable  input  1  core write strobe.
REQ-007 core_read_val  output  8  read data returned to the core.
REQ-008 core_stall  output  1  when high, the core SHALL hold all of its state.
REQ-009 clear_req  input  1  request to zero the whole data memory.
REQ-010 clear_busy  output  1  high while a clear sweep is in progress.
REQ-011 host_req, host_we  input  1 each  host access request and write select.
REQ-012 host_addr  input  DATA_ADDR_SIZE; host_wdata  input  8  host address and write data.
REQ-013 host_ack  output  1; host_rdata  output  8  one-cycle completion pulse and registered read data.
REQ-014 mem_cursor  output  DATA_ADDR_SIZE; mem_write_val  output  8; mem_write_enable  output  1  drive the data memory.
REQ-015 mem_read_val  input  8  asynchronous read data from the data memory.

Function
REQ-016 The FSM SHALL have three states: CLEAR, RUN, HOST.
REQ-017 In CLEAR: mem_cursor=clear_cnt, mem_write_val=0, mem_write_enable=1, core_stall=1, clear_busy=1; clear_cnt SHALL increment by 1 each cycle.
REQ-018 CLEAR -> RUN on the cycle where clear_cnt is all ones (that address is written first); a full sweep SHALL take 2^DATA_ADDR_SIZE cycles.
REQ-019 In RUN: mem_* SHALL pass core_cursor, core_write_val, core_write_enable combinationally; core_read_val=mem_read_val; core_stall=0.
REQ-020 RUN -> CLEAR when clear_req=1, with clear_cnt loaded to 0; clear_req SHALL take priority over host_req in the same cycle.
REQ-021 RUN -> HOST when host_req=1, clear_req=0 and host_ack=0; the core keeps memory for that RUN cycle.
REQ-022 In HOST (exactly one cycle): mem_cursor=host_addr, mem_write_val=host_wdata, mem_write_enable=host_we, core_stall=1; host_rdata SHALL capture mem_read_val at the end of the cycle; next state is RUN.
REQ-023 host_ack SHALL be a registered pulse, high for exactly the one cycle after HOST; host_rdata SHALL hold its value until the next HOST cycle.
REQ-024 core_stall SHALL be decoded from the registered state only; core_read_val SHALL be 8'h00 while core_stall=1.
REQ-025 clear_req during CLEAR SHALL be ignored; the sweep does not restart.
REQ-026 host_req during CLEAR SHALL wait; it is served in the first RUN cycle in which clear_req=0.
REQ-027 At most one memory write SHALL occur per cycle; the core and host SHALL never drive memory in the same cycle.

Reset
REQ-028 Reset SHALL set clear_cnt=0, host_ack=0 and host_rdata=8'h00, and SHALL abort any HOST access with no ack.
REQ-029 The reset state SHALL be set by REQ-031; a reset during CLEAR SHALL restart the sweep at address 0.

Configuration
REQ-030 Macro DMC_AUTO_CLEAR_EN selects the reset behaviour.
REQ-031 With DMC_AUTO_CLEAR_EN defined, reset SHALL enter CLEAR (clear_busy=1 on the first post-reset cycle); without it, reset SHALL enter RUN, and clearing SHALL occur only via clear_req.

Verification (DATA_ADDR_SIZE=4)
REQ-032 Macro defined; memory preloaded 0xAA; reset for 1 cycle -> 16 cycles with clear_busy=1 and mem_cursor 0..15, all 16 locations 0x00, RUN on cycle 17.
REQ-033 RUN; core writes 0x5A to address 3, then reads address 3 -> core_read_val=0x5A, core_stall=0 throughout.
REQ-034 RUN; host_req with we=0, addr=3 -> one HOST cycle with core_stall=1, then host_ack for 1 cycle with host_rdata=0x5A; core resumes in the ack cycle.
REQ-035 RUN; clear_req and host_req (we=1, addr=2, data=0x11) in the same cycle -> 16-cycle clear, then HOST; address 2=0x11, all other addresses 0x00.
REQ-036 Reset asserted at clear_cnt=7 -> sweep restarts at 0; with the macro undefined, reset -> RUN immediately, clear_busy=0 and memory unchanged.
REQ-037 Reset asserted during HOST -> no host_ack, and host_rdata=0x00.
